// File: rtl/mii_rx_checker.sv
// Passive MII receive-frame checker: tracks preamble/SFD, accumulates CRC-32,
// length and destination address, and reports a verdict plus good/bad counts.
module mii_rx_checker #(
  parameter logic [47:0] MAC_ADD       = 48'h0100_0000_0000,
  parameter int          FRAME_NIBBLES = 338
) (
  input  logic        phy_rxclk,
  input  logic        rst_n,
  input  logic [3:0]  phy_rxd,
  input  logic        phy_rxen,
  input  logic        phy_rxer,
  output logic        frame_done,
  output logic        crc_ok,
  output logic        len_ok,
  output logic        addr_ok,
  output logic        frame_good,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, WAIT_END} state_t;

  localparam logic [8:0]  LEN_EXP = 9'(FRAME_NIBBLES);
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [47:0] dst_q, dst_d;
  logic        rxer_q, rxer_d;
  logic        done_q, done_d;
  logic        crc_ok_q, crc_ok_d, len_ok_q, len_ok_d, addr_ok_q, addr_ok_d;
  logic        good_q, good_d;
  logic [15:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

  logic        v_crc, v_len, v_addr, v_good;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The register runs LSB-first, so the residue constant is matched in reversed bit order.
  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  always_comb begin
    v_crc  = (rev32(crc_q) == RESIDUE);
    v_len  = (cnt_q == LEN_EXP);
    v_addr = (cnt_q >= 9'd12) && (dst_q == MAC_ADD);
    v_good = v_crc && v_len && v_addr && !rxer_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    dst_d      = dst_q;
    rxer_d     = rxer_q;
    done_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    len_ok_d   = len_ok_q;
    addr_ok_d  = addr_ok_q;
    good_d     = good_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    case (state_q)
      IDLE: begin
        if (phy_rxen) state_d = (phy_rxd == 4'h5) ? PREAMBLE : WAIT_END;
      end
      PREAMBLE: begin
        if (!phy_rxen) state_d = IDLE;
        else if (phy_rxd == 4'hD) begin
          state_d = DATA;
          cnt_d   = '0;
          rxer_d  = 1'b0;
          crc_d   = 32'hFFFF_FFFF;
          dst_d   = '0;
        end else if (phy_rxd != 4'h5) state_d = WAIT_END;
      end
      DATA: begin
        if (phy_rxen) begin
          crc_d = crc_nib(crc_q, phy_rxd);
          if (cnt_q != 9'h1FF) cnt_d = cnt_q + 9'd1;
          if (cnt_q < 9'd12) dst_d = {phy_rxd, dst_q[47:4]};
          if (phy_rxer) rxer_d = 1'b1;
        end else begin
          state_d   = IDLE;
          done_d    = 1'b1;
          crc_ok_d  = v_crc;
          len_ok_d  = v_len;
          addr_ok_d = v_addr;
          good_d    = v_good;
          if (v_good) begin
            if (good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
          end else begin
            if (bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
          end
        end
      end
      WAIT_END: begin
        if (!phy_rxen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phy_rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      crc_q      <= 32'hFFFF_FFFF;
      dst_q      <= '0;
      rxer_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      len_ok_q   <= 1'b0;
      addr_ok_q  <= 1'b0;
      good_q     <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      dst_q      <= dst_d;
      rxer_q     <= rxer_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      len_ok_q   <= len_ok_d;
      addr_ok_q  <= addr_ok_d;
      good_q     <= good_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign frame_done = done_q;
  assign crc_ok     = crc_ok_q;
  assign len_ok     = len_ok_q;
  assign addr_ok    = addr_ok_q;
  assign frame_good = good_q;
  assign good_cnt   = good_cnt_q;
  assign bad_cnt    = bad_cnt_q;

endmodule

// File: tb/tb_mii_rx_checker.sv
// Directed + randomized frames against a byte-level Ethernet frame model.
module tb_mii_rx_checker;
  localparam logic [47:0] MAC = 48'h0100_0000_0000;
  localparam int          FN  = 338;

  logic        phy_rxclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  phy_rxd = 4'h0;
  logic        phy_rxen = 1'b0, phy_rxer = 1'b0;
  logic        frame_done, crc_ok, len_ok, addr_ok, frame_good;
  logic [15:0] good_cnt, bad_cnt;

  mii_rx_checker #(.MAC_ADD(MAC), .FRAME_NIBBLES(FN)) dut (
    .phy_rxclk(phy_rxclk), .rst_n(rst_n), .phy_rxd(phy_rxd), .phy_rxen(phy_rxen),
    .phy_rxer(phy_rxer), .frame_done(frame_done), .crc_ok(crc_ok), .len_ok(len_ok),
    .addr_ok(addr_ok), .frame_good(frame_good), .good_cnt(good_cnt), .bad_cnt(bad_cnt));

  always #5 phy_rxclk = ~phy_rxclk;

  int vectors = 0, miscompares = 0, done_seen = 0;
  int mg = 0, mb = 0;
  logic [7:0] frm[$];

  always @(negedge phy_rxclk) if (frame_done) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] d, input logic er);
    @(negedge phy_rxclk);
    phy_rxen = en; phy_rxd = d; phy_rxer = er;
  endtask

  // Standard Ethernet FCS over the first n bytes of frm.
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      c ^= {24'h0, frm[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dst, input int nbytes);
    logic [31:0] fcs;
    frm.delete();
    for (int k = 0; k < nbytes - 4; k++)
      frm.push_back(k < 6 ? dst[8*k +: 8] : 8'($urandom()));
    fcs = crc32(nbytes - 4);
    for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
  endtask

  task automatic run(input string tag, input logic [47:0] dst, input int nbytes,
                     input int flip, input int rxer_pos);
    logic [7:0] b;
    int n;
    logic ecrc, elen, eaddr, eer, egood;
    build(dst, nbytes);
    if (flip >= 0) begin
      b = frm[flip/2];
      b ^= (flip % 2) ? 8'h10 : 8'h01;
      frm[flip/2] = b;
    end
    n = frm.size();
    ecrc  = (crc32(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    elen  = (2 * n == FN);
    eaddr = (2 * n >= 12);
    for (int k = 0; k < 6 && k < n; k++) if (frm[k] != MAC[8*k +: 8]) eaddr = 1'b0;
    eer   = (rxer_pos >= 0) && (rxer_pos < 2 * n);
    egood = ecrc && elen && eaddr && !eer;
    if (egood) mg = (mg < 65535) ? mg + 1 : mg;
    else       mb = (mb < 65535) ? mb + 1 : mb;
    repeat (15) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 2 * n; i++) begin
      b = frm[i/2];
      drive(1'b1, (i % 2) ? b[7:4] : b[3:0], i == rxer_pos);
    end
    drive(1'b0, 4'h0, 1'b0);
    @(negedge phy_rxclk);
    chk({tag, ".done"}, 32'(frame_done), 32'd1);
    chk({tag, ".crc"},  32'(crc_ok),     32'(ecrc));
    chk({tag, ".len"},  32'(len_ok),     32'(elen));
    chk({tag, ".addr"}, 32'(addr_ok),    32'(eaddr));
    chk({tag, ".good"}, 32'(frame_good), 32'(egood));
    chk({tag, ".gcnt"}, 32'(good_cnt),   32'(mg));
    chk({tag, ".bcnt"}, 32'(bad_cnt),    32'(mb));
    @(negedge phy_rxclk);
    chk({tag, ".pulse"}, 32'(frame_done), 32'd0);
    chk({tag, ".hold"},  32'(frame_good), 32'(egood));
  endtask

  initial begin
    int d0, nb, fl, er;
    logic [47:0] dst;
    #12;
    chk("rst.done", 32'(frame_done), 32'd0);
    chk("rst.flags", {28'h0, crc_ok, len_ok, addr_ok, frame_good}, 32'd0);
    chk("rst.gcnt", 32'(good_cnt), 32'd0);
    chk("rst.bcnt", 32'(bad_cnt), 32'd0);
    @(negedge phy_rxclk); rst_n = 1'b1;
    repeat (3) drive(1'b0, 4'h5, 1'b1);

    run("good",   MAC, 169, -1, -1);
    run("flip",   MAC, 169, 200, -1);
    run("addr2",  48'h0200_0000_0000, 169, -1, -1);
    run("len336", MAC, 168, -1, -1);
    run("len340", MAC, 170, -1, -1);
    run("rxer100", MAC, 169, -1, 100);
    run("tiny",   MAC, 4, -1, -1);

    d0 = done_seen;
    repeat (7) drive(1'b1, 4'h5, 1'b0);
    repeat (3) drive(1'b0, 4'h0, 1'b1);
    drive(1'b1, 4'hA, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    repeat (20) drive(1'b1, 4'($urandom()), 1'b0);
    repeat (3) drive(1'b0, 4'h0, 1'b0);
    chk("nodone.pulses", 32'(done_seen), 32'(d0));
    chk("nodone.gcnt", 32'(good_cnt), 32'(mg));
    chk("nodone.bcnt", 32'(bad_cnt), 32'(mb));

    for (int r = 0; r < 6; r++) begin
      dst = $urandom_range(0, 1) ? MAC : 48'({$urandom(), $urandom()});
      case ($urandom_range(0, 3)) 0: nb = 168; 1: nb = 170; default: nb = 169; endcase
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 300)) : -1;
      er = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 320)) : -1;
      run("rand", dst, nb, fl, er);
    end

    @(negedge phy_rxclk);
    force dut.good_cnt_q = 16'hFFFE;
    #2 release dut.good_cnt_q;
    mg = 65534;
    @(negedge phy_rxclk);
    chk("preload.gcnt", 32'(good_cnt), 32'(mg));
    repeat (3) run("sat", MAC, 169, -1, -1);
    chk("sat.final", 32'(good_cnt), 32'h0000_FFFF);

    d0 = done_seen;
    repeat (15) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    repeat (50) drive(1'b1, 4'($urandom()), 1'b0);
    @(negedge phy_rxclk);
    rst_n = 1'b0; phy_rxen = 1'b1; phy_rxd = 4'hA;
    #1;
    mg = 0; mb = 0;
    chk("midrst.gcnt", 32'(good_cnt), 32'd0);
    chk("midrst.bcnt", 32'(bad_cnt), 32'd0);
    chk("midrst.flags", {27'h0, frame_done, crc_ok, len_ok, addr_ok, frame_good}, 32'd0);
    repeat (2) @(negedge phy_rxclk);
    rst_n = 1'b1;
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    repeat (30) drive(1'b1, 4'($urandom()), 1'b0);
    repeat (3) drive(1'b0, 4'h0, 1'b0);
    chk("midrst.pulses", 32'(done_seen), 32'(d0));
    chk("midrst.gcnt2", 32'(good_cnt), 32'd0);
    run("recover", MAC, 169, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mii_rx_checker.md
MII_RX_CHECKER -- requirements
Module: mii_rx_checker

Interface
REQ-001 Parameter MAC_ADD, default 48'h0100_0000_0000, station address packed first-received byte in bits [7:0] (wire order 00-00-00-00-00-01).
REQ-002 Parameter FRAME_NIBBLES, default 338, exact post-SFD nibble count of a valid frame (dst+src+type+3+148+FCS bytes, times 2).
REQ-003 phy_rxclk  input  1  MII receive clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 phy_rxd  input  4  MII receive nibble, low nibble of each byte first.
REQ-006 phy_rxen  input  1  MII receive data valid.
REQ-007 phy_rxer  input  1  MII receive error.
REQ-008 frame_done  output  1  one-cycle pulse on completion of each checked frame.
REQ-009 crc_ok, len_ok, addr_ok  output  1 each  verdict flags of the last completed frame.
REQ-010 frame_good  output  1  crc_ok & len_ok & addr_ok & no rxer seen; last completed frame.
REQ-011 good_cnt, bad_cnt  output  16 each  saturating counts of good and bad frames.

Function
REQ-012 The checker SHALL run alongside the downstream frame buffer on the same MII signals and SHALL NOT modify them.
REQ-013 State machine SHALL have states IDLE, PREAMBLE, DATA, WAIT_END.
REQ-014 IDLE: phy_rxen=1 and phy_rxd=4'h5 -> PREAMBLE; phy_rxen=1 with any other nibble -> WAIT_END.
REQ-015 PREAMBLE: phy_rxd=4'h5 stays; 4'hD -> DATA, clearing nibble count, rxer flag, CRC to 32'hFFFF_FFFF; other nibble -> WAIT_END; phy_rxen=0 -> IDLE with no frame_done.
REQ-016 DATA, phy_rxen=1: each nibble updates CRC (reflected poly 32'hEDB8_8320, four bit steps per nibble, bit 0 first), increments 9-bit nibble count, saturating at 511.
REQ-017 DATA: nibbles 0..11 SHALL load a 48-bit destination shift register, first nibble ending in bits [3:0].
REQ-018 DATA: phy_rxer=1 while phy_rxen=1 SHALL set the rxer flag; state stays DATA.
REQ-019 DATA, phy_rxen=0 -> IDLE; same edge: frame_done=1, crc_ok=(CRC==32'hC704_DD7B), len_ok=(count==FRAME_NIBBLES), addr_ok=(dst==MAC_ADD), frame_good per REQ-010.
REQ-020 Verdict flags SHALL hold until the next frame_done.
REQ-021 On frame_done exactly one of good_cnt/bad_cnt increments, each stopping at 16'hFFFF.
REQ-022 WAIT_END: phy_rxen=0 -> IDLE; no frame_done, no counter change.
REQ-023 phy_rxer with phy_rxen=0 (carrier events) SHALL be ignored in all states.
REQ-024 A frame with fewer than 12 nibbles SHALL have addr_ok=0 and len_ok=0.
REQ-025 Latency: frame_done is asserted on the first phy_rxclk edge that samples phy_rxen=0 after DATA.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, frame_done=0, crc_ok=len_ok=addr_ok=frame_good=0, good_cnt=bad_cnt=0, nibble count 0, CRC 32'hFFFF_FFFF.
REQ-027 Release of rst_n while phy_rxen=1 SHALL enter WAIT_END on the first edge unless the nibble is 4'h5; the partial frame SHALL NOT be counted.
REQ-028 Reset asserted mid-frame SHALL discard the frame without a frame_done pulse.

Verification
REQ-029 15x 4'h5, 4'hD, 338 nibbles to MAC_ADD with correct FCS, rxen low -> frame_done 1 cycle, all flags 1, good_cnt=1, bad_cnt=0.
REQ-030 Same frame, one payload nibble flipped -> crc_ok=0, len_ok=1, addr_ok=1, frame_good=0, bad_cnt=1.
REQ-031 Correct-CRC frame to 00-00-00-00-00-02 -> addr_ok=0, crc_ok=1, bad_cnt increments.
REQ-032 Correct-CRC frame of 336 nibbles, then one of 340 nibbles -> len_ok=0 both, bad_cnt +2.
REQ-033 phy_rxer=1 for one nibble at position 100 of a good frame -> frame_good=0, crc_ok per data; rxen drops during preamble -> no frame_done.
REQ-034 Preload good_cnt to 16'hFFFE, send 3 good frames -> good_cnt=16'hFFFF; rst_n pulse mid-frame -> counters 0, no frame_done.
